// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state codes, opcode/funct constants and ALU_Control encodings
// for the multicycle MIPS controller.
package mips_ctrl_pkg;

  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADR  = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_EXEC_R  = 4'd6;
  localparam logic [3:0] ST_ALUWB   = 4'd7;
  localparam logic [3:0] ST_BRANCH  = 4'd8;
  localparam logic [3:0] ST_ADDI_EX = 4'd9;
  localparam logic [3:0] ST_ADDI_WB = 4'd10;
  localparam logic [3:0] ST_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MULT = 6'h18;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // States that stall on Mem_Ready and are covered by the timeout counter.
  function automatic logic is_mem_wait(input logic [3:0] st);
    return (st == ST_FETCH) || (st == ST_MEMRD) || (st == ST_MEMWR);
  endfunction

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - instruction/status inputs and datapath control outputs
// of the multicycle controller; master = controller, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero_Flag;
  logic       Mem_Ready;

  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALU_Control;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic       Illegal_Op;
  logic       Mem_Err;

  modport master (
    input  Opcode, Funct, Zero_Flag, Mem_Ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALU_Control, PCSrc, PCWrite, Illegal_Op, Mem_Err
  );

  modport slave (
    output Opcode, Funct, Zero_Flag, Mem_Ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALU_Control, PCSrc, PCWrite, Illegal_Op, Mem_Err
  );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - ALUOp + Funct to ALU_Control decode with funct legality flag;
// macro MIPS_CTRL_MUL_EN enables the mult funct.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
`ifdef MIPS_CTRL_MUL_EN
          FN_MULT: alu_control = ALU_MUL;
`else
          FN_MULT: funct_illegal = 1'b1;
`endif
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM with bounded memory wait;
// mult support follows macro MIPS_CTRL_MUL_EN (in alu_decoder).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [3:0]       state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  alu_op_e          alu_op;
  logic [2:0]       alu_ctl;
  logic             funct_illegal;
  logic             timeout;
  logic             strobe_en;

  logic       iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_write, illegal_op;

  assign alu_op = (state == ST_EXEC_R) ? ALUOP_FUNCT :
                  (state == ST_BRANCH) ? ALUOP_SUB : ALUOP_ADD;

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (bus.Funct),
    .alu_control   (alu_ctl),
    .funct_illegal (funct_illegal)
  );

  // Ready on the limit cycle still completes normally.
  assign timeout   = is_mem_wait(state) && !bus.Mem_Ready && (wait_cnt == CNT_LIMIT);
  assign strobe_en = rst_n && !timeout;

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:   if (bus.Mem_Ready) state_next = ST_DECODE;
      ST_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_EXEC_R;
          OP_BEQ:       state_next = ST_BRANCH;
          OP_ADDI:      state_next = ST_ADDI_EX;
          OP_J:         state_next = ST_JUMP;
          default:      state_next = ST_FETCH;
        endcase
      end
      ST_MEMADR:  state_next = (bus.Opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   if (bus.Mem_Ready) state_next = ST_MEMWB;
      ST_MEMWR:   if (bus.Mem_Ready) state_next = ST_FETCH;
      ST_EXEC_R:  state_next = funct_illegal ? ST_FETCH : ST_ALUWB;
      ST_ADDI_EX: state_next = ST_ADDI_WB;
      default:    state_next = ST_FETCH;
    endcase
    if (timeout) state_next = ST_FETCH;
  end

  // Any transition (including an abort back into FETCH) restarts the wait count.
  always_comb begin
    if (timeout || (state_next != state))
      wait_cnt_next = '0;
    else if (is_mem_wait(state) && !bus.Mem_Ready)
      wait_cnt_next = wait_cnt + 1'b1;
    else
      wait_cnt_next = wait_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    memto_reg  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    illegal_op = 1'b0;
    case (state)
      ST_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = bus.Mem_Ready;
        pc_write  = bus.Mem_Ready;
      end
      ST_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !op_is_legal(bus.Opcode);
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_MEMRD: iord = 1'b1;
      ST_MEMWB: begin
        memto_reg = 1'b1;
        reg_write = 1'b1;
      end
      ST_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a  = 1'b1;
        illegal_op = funct_illegal;
      end
      ST_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = 2'b01;
        pc_write  = bus.Zero_Flag;
      end
      ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_ADDI_WB: reg_write = 1'b1;
      ST_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.IorD        = iord;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = memto_reg;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALU_Control = alu_ctl;
  assign bus.PCSrc       = pc_src;
  assign bus.MemWrite    = mem_write  && strobe_en;
  assign bus.IRWrite     = ir_write   && strobe_en;
  assign bus.RegWrite    = reg_write  && strobe_en;
  assign bus.PCWrite     = pc_write   && strobe_en;
  assign bus.Illegal_Op  = illegal_op && strobe_en;
  assign bus.Mem_Err     = timeout    && rst_n;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed bench with per-cycle phase model for mips_multicycle_ctrl.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_write, illegal_op, mem_err;
  } ctl_t;

  localparam int P_RESET = 0, P_F = 1, P_F_TO = 2, P_D = 3, P_A = 4, P_RD = 5, P_MWB = 6,
                 P_WR = 7, P_WR_TO = 8, P_EX = 9, P_AWB = 10, P_BR = 11, P_AE = 12,
                 P_AW = 13, P_J = 14;
`ifdef MIPS_CTRL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0, n_fail = 0;
  logic chk_en = 1'b0;
  ctl_t exp_c;
  string tag = "reset";
  int cur_ph;
  logic [5:0] cur_op, cur_fn;
  logic cur_zf;
  int o_cyc, o_iord, o_regw, o_memw, o_ill, o_pcw, o_irw, o_err_at;
  logic o_regdst, o_memto;
  logic [2:0] o_alu_ex;

  function automatic logic [3:0] alu_model(input logic [5:0] fn);
    case (fn)
      6'h20: return {1'b0, 3'b010};
      6'h22: return {1'b0, 3'b100};
      6'h24: return {1'b0, 3'b000};
      6'h25: return {1'b0, 3'b001};
      6'h2A: return {1'b0, 3'b110};
      6'h18: return MUL_EN ? {1'b0, 3'b101} : {1'b1, 3'b010};
      default: return {1'b1, 3'b010};
    endcase
  endfunction

  function automatic logic op_ok(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08 || op == 6'h02;
  endfunction

  // Expected outputs for one cycle of a given instruction phase.
  function automatic ctl_t row(input int ph, input logic rdy);
    ctl_t c = '0;
    logic [3:0] a;
    c.alu_control = 3'b010;
    case (ph)
      P_RESET: c.alu_src_b = 2'b01;
      P_F:     begin c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      P_F_TO:  begin c.alu_src_b = 2'b01; c.mem_err = 1'b1; end
      P_D:     begin c.alu_src_b = 2'b11; c.illegal_op = !op_ok(cur_op); end
      P_A:     begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      P_RD:    c.iord = 1'b1;
      P_MWB:   begin c.memto_reg = 1'b1; c.reg_write = 1'b1; end
      P_WR:    begin c.iord = 1'b1; c.mem_write = 1'b1; end
      P_WR_TO: begin c.iord = 1'b1; c.mem_err = 1'b1; end
      P_EX:    begin
        a = alu_model(cur_fn);
        c.alu_src_a = 1'b1; c.illegal_op = a[3]; c.alu_control = a[2:0];
      end
      P_AWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      P_BR:    begin
        c.alu_src_a = 1'b1; c.alu_control = 3'b100; c.pc_src = 2'b01; c.pc_write = cur_zf;
      end
      P_AE:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      P_AW:    c.reg_write = 1'b1;
      P_J:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t s;
    s = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
         bus.ALUSrcA, bus.ALUSrcB, bus.ALU_Control, bus.PCSrc, bus.PCWrite, bus.Illegal_Op,
         bus.Mem_Err};
    return s;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (sample() !== exp_c) begin
        n_fail++;
        $display("FAIL cycle[%s ph%0d] @%0t: got %h, expected %h", tag, cur_ph, $time, sample(), exp_c);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic clear_obs();
    o_cyc = 0; o_iord = 0; o_regw = 0; o_memw = 0; o_ill = 0; o_pcw = 0; o_irw = 0;
    o_err_at = 0; o_regdst = 1'b0; o_memto = 1'b0; o_alu_ex = 3'b111;
  endtask

  task automatic set(input logic rdy, input int ph);
    bus.Mem_Ready = rdy;
    cur_ph = ph;
    exp_c = row(ph, rdy);
    chk_en = 1'b1;
  endtask

  task automatic adv();
    #2;
    o_cyc++;
    if (bus.IorD) o_iord++;
    if (bus.MemWrite) o_memw++;
    if (bus.Illegal_Op) o_ill++;
    if (bus.PCWrite) o_pcw++;
    if (bus.IRWrite) o_irw++;
    if (bus.RegWrite) begin o_regw++; o_regdst = bus.RegDst; o_memto = bus.MemtoReg; end
    if (bus.Mem_Err && o_err_at == 0) o_err_at = o_cyc;
    if (cur_ph == P_EX) o_alu_ex = bus.ALU_Control;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                     input int fw, input int mw, input string nm);
    logic [3:0] a;
    int mph;
    tag = nm; cur_op = op; cur_fn = fn; cur_zf = zf;
    bus.Opcode = op; bus.Funct = fn; bus.Zero_Flag = zf;
    clear_obs();
    repeat (fw) begin set(1'b0, P_F); adv(); end
    set(1'b1, P_F); adv();
    set(1'b0, P_D); adv();
    if (op == 6'h23 || op == 6'h2B) begin
      mph = (op == 6'h23) ? P_RD : P_WR;
      set(1'b0, P_A); adv();
      repeat (mw) begin set(1'b0, mph); adv(); end
      set(1'b1, mph); adv();
      if (op == 6'h23) begin set(1'b0, P_MWB); adv(); end
    end else if (op == 6'h00) begin
      a = alu_model(fn);
      set(1'b0, P_EX); adv();
      if (!a[3]) begin set(1'b0, P_AWB); adv(); end
    end else if (op == 6'h04) begin
      set(1'b0, P_BR); adv();
    end else if (op == 6'h08) begin
      set(1'b0, P_AE); adv();
      set(1'b0, P_AW); adv();
    end else if (op == 6'h02) begin
      set(1'b0, P_J); adv();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.Opcode = 6'h00; bus.Funct = 6'h20; bus.Zero_Flag = 1'b0;
    cur_op = 6'h00; cur_fn = 6'h20; cur_zf = 1'b0;
    set(1'b1, P_RESET);
    #3;
    check_lit("reset_irwrite", int'(bus.IRWrite), 0);
    check_lit("reset_pcwrite", int'(bus.PCWrite), 0);
    check_lit("reset_alusrcb", int'(bus.ALUSrcB), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(6'h00, 6'h20, 1'b0, 0, 0, "add");
    check_lit("add_alu_ex", int'(o_alu_ex), 3'b010);
    check_lit("add_regwrite_cnt", o_regw, 1);
    check_lit("add_regdst", int'(o_regdst), 1);
    run(6'h00, 6'h22, 1'b0, 2, 0, "sub_fwait");
    check_lit("sub_alu_ex", int'(o_alu_ex), 3'b100);
    run(6'h00, 6'h24, 1'b0, 0, 0, "and");
    run(6'h00, 6'h25, 1'b0, 0, 0, "or");
    run(6'h00, 6'h2A, 1'b0, 0, 0, "slt");
    check_lit("slt_alu_ex", int'(o_alu_ex), 3'b110);

    run(6'h23, 6'h00, 1'b0, 0, 3, "lw_wait3");
    check_lit("lw_iord_cycles", o_iord, 4);
    check_lit("lw_memtoreg", int'(o_memto), 1);
    check_lit("lw_regwrite_cnt", o_regw, 1);
    run(6'h23, 6'h00, 1'b0, 0, 0, "lw");
    run(6'h2B, 6'h00, 1'b0, 0, 0, "sw");
    check_lit("sw_memwrite_cnt", o_memw, 1);
    run(6'h2B, 6'h00, 1'b0, 0, 2, "sw_wait2");
    check_lit("sw2_memwrite_cnt", o_memw, 3);
    check_lit("sw2_regwrite_cnt", o_regw, 0);

    run(6'h04, 6'h00, 1'b1, 0, 0, "beq_taken");
    check_lit("beq_taken_pcwrite_cnt", o_pcw, 2);
    run(6'h04, 6'h00, 1'b0, 0, 0, "beq_not_taken");
    check_lit("beq_nt_pcwrite_cnt", o_pcw, 1);
    run(6'h08, 6'h00, 1'b0, 0, 0, "addi");
    run(6'h02, 6'h00, 1'b0, 0, 0, "j");

    run(6'h3F, 6'h20, 1'b0, 0, 0, "illegal_op");
    check_lit("illop_pulses", o_ill, 1);
    check_lit("illop_regwrite", o_regw, 0);
    check_lit("illop_memwrite", o_memw, 0);
    run(6'h00, 6'h3F, 1'b0, 0, 0, "illegal_funct");
    check_lit("illfn_pulses", o_ill, 1);
    check_lit("illfn_regwrite", o_regw, 0);
    run(6'h00, 6'h18, 1'b0, 0, 0, "mult");
    check_lit("mult_alu_ex", int'(o_alu_ex), MUL_EN ? 3'b101 : 3'b010);
    check_lit("mult_regwrite", o_regw, MUL_EN ? 1 : 0);
    check_lit("mult_illegal", o_ill, MUL_EN ? 0 : 1);

    // Fetch stuck: abort on the 16th waiting cycle.
    tag = "fetch_timeout"; clear_obs();
    for (int i = 1; i <= 16; i++) begin
      set(1'b0, (i < 16) ? P_F : P_F_TO); adv();
    end
    check_lit("fetch_timeout_cycle", o_err_at, 16);
    check_lit("fetch_timeout_irwrite", o_irw, 0);

    // Counter restarts after the abort; ready on the limit cycle completes.
    run(6'h00, 6'h20, 1'b0, 15, 0, "add_ready_at_limit");
    check_lit("limit_no_err", o_err_at, 0);
    check_lit("limit_irwrite", o_irw, 1);

    tag = "memwr_timeout"; clear_obs();
    cur_op = 6'h2B; bus.Opcode = 6'h2B;
    set(1'b1, P_F); adv();
    set(1'b0, P_D); adv();
    set(1'b0, P_A); adv();
    for (int i = 1; i <= 16; i++) begin
      set(1'b0, (i < 16) ? P_WR : P_WR_TO); adv();
    end
    check_lit("memwr_timeout_cycle", o_err_at, 19);
    check_lit("memwr_timeout_memwrite", o_memw, 15);

    tag = "reset_mid_memwr";
    set(1'b1, P_F); adv();
    set(1'b0, P_D); adv();
    set(1'b0, P_A); adv();
    set(1'b0, P_WR); adv();
    set(1'b0, P_WR);
    #1;
    check_lit("memwr_before_reset", int'(bus.MemWrite), 1);
    rst_n = 1'b0;
    cur_ph = P_RESET; exp_c = row(P_RESET, 1'b0);
    #1;
    check_lit("memwr_at_reset", int'(bus.MemWrite), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(6'h00, 6'h25, 1'b0, 0, 0, "or_after_reset");
    check_lit("or_after_reset_alu", int'(o_alu_ex), 3'b001);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
